// File: rtl/rand_pkg.sv
// rand_pkg: shared types and constants for the pseudo-random operand source.
//   RAND_WIDTH    LFSR / output width (only 10 is supported with these taps)
//   LOCKUP        all-ones lock-up state of the XNOR LFSR
//   TAP_HI/TAP_LO feedback tap indices (taps 10 and 7, 1-based)
//   rand_t        RAND_WIDTH-bit value type
//   lfsr_next     one LFSR step
//   fix_seed      maps the lock-up value to zero so it can never be loaded
package rand_pkg;

  localparam int RAND_WIDTH = 10;
  localparam logic [RAND_WIDTH-1:0] LOCKUP = 10'h3FF;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  typedef logic [RAND_WIDTH-1:0] rand_t;

  function automatic rand_t lfsr_next(input rand_t q);
    return {q[RAND_WIDTH-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
  endfunction

  function automatic rand_t fix_seed(input rand_t s);
    return (s == LOCKUP) ? '0 : s;
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_pace_counter.sv
// pace_counter: modulo-PERIOD counter producing the LFSR advance strobe.
//   clk     system clock
//   Reset   synchronous active-high reset
//   enable  count enable; the count holds while low
//   clear   returns the count to 0 (seed load)
//   tick    combinational strobe, high in the PERIOD-th enabled cycle
module pace_counter #(
  parameter int PERIOD = 4,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (Reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: paced 10-bit XNOR LFSR feeding the comparator B operand.
//   clk       system clock
//   Reset     synchronous active-high reset
//   enable    runs the pace counter
//   seedLoad  loads seed into the LFSR and clears the pace counter
//   seed      seed value (0x3FF is replaced by 0x000)
//   B         current random value (the LFSR register itself)
//   newValue  one-cycle pulse while B holds a freshly advanced value
//   wrapped   (RAND_WRAP_FLAG_EN only) pulses with newValue when the sequence
//             returns to the value it started from
// Optional feature macro: RAND_WRAP_FLAG_EN.
module lfsr_rand_gen
  import rand_pkg::*;
#(
  parameter int WIDTH  = RAND_WIDTH,
  parameter int PERIOD = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             enable,
  input  logic             seedLoad,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] B,
  output logic             newValue
`ifdef RAND_WRAP_FLAG_EN
  ,
  output logic             wrapped
`endif
);

  rand_t lfsr_q;
  rand_t lfsr_nxt;
  rand_t seed_fixed;
  logic  tick;
  logic  advance;

  pace_counter #(
    .PERIOD(PERIOD),
    .CNT_W (CNT_W)
  ) u_pace (
    .clk   (clk),
    .Reset (Reset),
    .enable(enable),
    .clear (seedLoad),
    .tick  (tick)
  );

  // A load in the same cycle as a tick suppresses the advance.
  assign advance    = tick && !seedLoad;
  assign lfsr_nxt   = lfsr_next(lfsr_q);
  assign seed_fixed = fix_seed(seed);

  always_ff @(posedge clk) begin
    if (Reset) begin
      lfsr_q   <= '0;
      newValue <= 1'b0;
    end else begin
      newValue <= advance;
      if (seedLoad) begin
        lfsr_q <= seed_fixed;
      end else if (advance) begin
        lfsr_q <= lfsr_nxt;
      end
    end
  end

  assign B = lfsr_q;

`ifdef RAND_WRAP_FLAG_EN
  rand_t start_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      start_q <= '0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= advance && (lfsr_nxt == start_q);
      if (seedLoad) begin
        start_q <= seed_fixed;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
module tb_lfsr_rand_gen;

  localparam int PERIOD_A = 4;
  localparam int PERIOD_B = 1;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: PERIOD=4
  logic       rst_a = 1'b1, en_a = 1'b0, sl_a = 1'b0;
  logic [9:0] seed_a = '0;
  logic [9:0] b_a;
  logic       nv_a;
  // DUT b: PERIOD=1
  logic       rst_b = 1'b1, en_b = 1'b0, sl_b = 1'b0;
  logic [9:0] seed_b = '0;
  logic [9:0] b_b;
  logic       nv_b;
`ifdef RAND_WRAP_FLAG_EN
  logic       wr_a, wr_b;
`endif

  lfsr_rand_gen #(.WIDTH(10), .PERIOD(PERIOD_A), .CNT_W(16)) dut_a (
    .clk(clk), .Reset(rst_a), .enable(en_a), .seedLoad(sl_a), .seed(seed_a),
    .B(b_a), .newValue(nv_a)
`ifdef RAND_WRAP_FLAG_EN
    , .wrapped(wr_a)
`endif
  );

  lfsr_rand_gen #(.WIDTH(10), .PERIOD(PERIOD_B), .CNT_W(16)) dut_b (
    .clk(clk), .Reset(rst_b), .enable(en_b), .seedLoad(sl_b), .seed(seed_b),
    .B(b_b), .newValue(nv_b)
`ifdef RAND_WRAP_FLAG_EN
    , .wrapped(wr_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the spec's rule in plain arithmetic.
  function automatic int ref_next(input int x);
    int fb;
    fb = 1 - (((x / 512) % 2) ^ ((x / 64) % 2));
    return ((x * 2) % 1024) + fb;
  endfunction

  // Behavioural model state: value, enabled cycles since last advance,
  // expected pulses and the value the sequence started from.
  typedef struct {
    int val; int cnt; int nv; int wrap; int start;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(input model_t m, input int period,
                                        input logic r, input logic en,
                                        input logic sl, input logic [9:0] sd);
    model_t n;
    n = m;
    n.nv = 0;
    n.wrap = 0;
    if (r) begin
      n.val = 0; n.cnt = 0; n.start = 0;
    end else if (sl) begin
      n.val = (sd == 10'h3FF) ? 0 : int'(sd);
      n.cnt = 0;
      n.start = n.val;
    end else if (en) begin
      n.cnt = n.cnt + 1;
      if (n.cnt == period) begin
        n.cnt = 0;
        n.val = ref_next(n.val);
        n.nv = 1;
        n.wrap = (n.val == n.start) ? 1 : 0;
      end
    end
    return n;
  endfunction

  task automatic step_a(input logic r, input logic en, input logic sl, input logic [9:0] sd);
    rst_a = r; en_a = en; sl_a = sl; seed_a = sd;
    @(posedge clk);
    ma = model_step(ma, PERIOD_A, r, en, sl, sd);
    #1;
    chk("a_B", int'(b_a), ma.val);
    chk("a_newValue", int'(nv_a), ma.nv);
    chk("a_no_lockup", int'(b_a == 10'h3FF), 0);
`ifdef RAND_WRAP_FLAG_EN
    chk("a_wrapped", int'(wr_a), ma.wrap);
`endif
  endtask

  task automatic step_b(input logic r, input logic en, input logic sl, input logic [9:0] sd);
    rst_b = r; en_b = en; sl_b = sl; seed_b = sd;
    @(posedge clk);
    mb = model_step(mb, PERIOD_B, r, en, sl, sd);
    #1;
    chk("b_B", int'(b_b), mb.val);
    chk("b_newValue", int'(nv_b), mb.nv);
    chk("b_no_lockup", int'(b_b == 10'h3FF), 0);
`ifdef RAND_WRAP_FLAG_EN
    chk("b_wrapped", int'(wr_b), mb.wrap);
`endif
  endtask

  // Steps with enable high until newValue, returns the number of steps taken
  // (bounded; a missing pulse shows up as a wrong count).
  task automatic cycles_to_pulse(output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 10'h000);
      n++;
      if (nv_a) break;
    end
  endtask

  int seq_exp[4] = '{10'h001, 10'h003, 10'h007, 10'h00F};

  initial begin
    int n;
    int k;
    logic r, en, sl;
    logic [9:0] sd;
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};

    // Reset held 4 cycles, then idle with enable low.
    for (int i = 0; i < 4; i++) step_a(1'b1, 1'b0, 1'b0, 10'h000);
    chk("reset_B", int'(b_a), 0);
    chk("reset_newValue", int'(nv_a), 0);
    for (int i = 0; i < 10; i++) step_a(1'b0, 1'b0, 1'b0, 10'h000);
    chk("idle_B", int'(b_a), 0);

    // Paced run from 0: pulse every 4th cycle, fixed sequence.
    k = 0;
    for (int i = 0; i < 16; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 10'h000);
      if (nv_a) begin
        chk("pulse_spacing", i % PERIOD_A, PERIOD_A - 1);
        if (k < 4) chk("seq_from_zero", int'(b_a), seq_exp[k]);
        k++;
      end
    end
    chk("pulse_count", k, 4);

    // Enable gap resumes the held count.
    step_a(1'b1, 1'b0, 1'b0, 10'h000);
    step_a(1'b0, 1'b1, 1'b0, 10'h000);
    step_a(1'b0, 1'b1, 1'b0, 10'h000);
    for (int i = 0; i < 5; i++) step_a(1'b0, 1'b0, 1'b0, 10'h000);
    chk("gap_hold_B", int'(b_a), 0);
    cycles_to_pulse(n);
    chk("gap_resume_cycles", n, 2);
    chk("gap_resume_B", int'(b_a), 10'h001);

    // Lock-up seed replaced by zero.
    step_a(1'b0, 1'b0, 1'b1, 10'h3FF);
    chk("seed_lockup_B", int'(b_a), 0);

    // Seed load on a pace-tick cycle wins; next advance a full period later.
    step_a(1'b1, 1'b0, 1'b0, 10'h000);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b0, 10'h000);
    step_a(1'b0, 1'b1, 1'b1, 10'h155);
    chk("seed_tick_B", int'(b_a), 10'h155);
    chk("seed_tick_newValue", int'(nv_a), 0);
    cycles_to_pulse(n);
    chk("seed_next_cycles", n, 4);
    chk("seed_next_B", int'(b_a), ref_next(10'h155));

    // Reset mid-count after B=0x007.
    step_a(1'b1, 1'b0, 1'b0, 10'h000);
    for (int i = 0; i < 12; i++) step_a(1'b0, 1'b1, 1'b0, 10'h000);
    chk("pre_reset_B", int'(b_a), 10'h007);
    step_a(1'b0, 1'b1, 1'b0, 10'h000);
    step_a(1'b0, 1'b1, 1'b0, 10'h000);
    step_a(1'b1, 1'b1, 1'b0, 10'h000);
    chk("mid_reset_B", int'(b_a), 0);
    chk("mid_reset_newValue", int'(nv_a), 0);
    cycles_to_pulse(n);
    chk("mid_reset_cycles", n, 4);
    chk("mid_reset_next_B", int'(b_a), 10'h001);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      en = ($urandom_range(0, 99) < 75);
      sl = ($urandom_range(0, 99) < 6);
      sd = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
      step_a(r, en, sl, sd);
    end

    // PERIOD=1: full cycle from seed 0x2A5.
    step_b(1'b1, 1'b0, 1'b0, 10'h000);
    step_b(1'b1, 1'b0, 1'b0, 10'h000);
    step_b(1'b0, 1'b0, 1'b1, 10'h2A5);
    chk("p1_seed_B", int'(b_b), 10'h2A5);
    for (int i = 1; i <= 1023; i++) begin
      step_b(1'b0, 1'b1, 1'b0, 10'h000);
      if (i < 1023 && b_b == 10'h2A5) chk("p1_early_return", i, 1023);
    end
    chk("p1_wrap_B", int'(b_b), 10'h2A5);
    chk("p1_newValue_continuous", int'(nv_b), 1);
`ifdef RAND_WRAP_FLAG_EN
    chk("p1_wrapped", int'(wr_b), 1);
`endif
    step_b(1'b0, 1'b1, 1'b0, 10'h000);
`ifdef RAND_WRAP_FLAG_EN
    chk("p1_wrapped_single", int'(wr_b), 0);
`endif
    step_b(1'b0, 1'b0, 1'b0, 10'h000);
    chk("p1_disable_newValue", int'(nv_b), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
- Pseudo-random 10-bit value source for the computer player.
- Feeds the B operand of the magnitude comparator that decides the computer press; the A operand comes from the switches.
- Internally a maximal-length XNOR LFSR, advanced at a paced rate so the comparator sees a stable value between updates.
- Supports seed loading and an enable gate.

Parameters:
- WIDTH, 10: LFSR and output width. Only 10 is supported with the default taps.
- PERIOD, 4: number of enabled clk cycles per LFSR advance. Must be at least 1.
- CNT_W, 16: pace counter width. Must satisfy 2^CNT_W ≥ PERIOD.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- enable  input  1  when high, the pace counter runs.
- seedLoad  input  1  one-cycle request to load seed into the LFSR.
- seed  input  WIDTH  seed value, sampled when seedLoad is high.
- B  output  WIDTH  current random value (registered) to the comparator.
- newValue  output  1  one-cycle pulse in the cycle B holds a freshly advanced value.
- wrapped  output  1  present only with RAND_WRAP_FLAG_EN; see Optional Feature.

Behaviour:
- One clock domain; synchronous, active-high reset.
- Reset (highest priority): LFSR state = 0, B = 0, pace counter = 0, newValue = 0, wrapped = 0.
- Next-state function: next = {q[8:0], ~(q[9] ^ q[6])}. This is XNOR, taps 10 and 7, period 1023.
- Lock-up state: all-ones (10'h3FF) is the XNOR lock-up state and must never be entered.
- B is the LFSR state register itself; no extra pipeline stage.
- Pacing:
  - enable high: the counter increments each cycle.
  - When counter == PERIOD-1: the counter returns to 0, the LFSR advances at that same edge, and newValue is high for the following cycle only.
  - Latency: newValue asserts in the cycle after the PERIOD-th enabled cycle.
- Enable low: counter and LFSR hold; newValue = 0. Re-raising enable resumes the count from the held value; the count is not restarted.
- PERIOD = 1: the LFSR advances every enabled cycle and newValue stays high continuously while enable is high.
- Seed load (priority over pacing):
  - seedLoad high: LFSR takes seed, counter clears to 0, newValue = 0 next cycle.
  - seed == 10'h3FF is replaced by 10'h000.
  - A seed load in the same cycle as a pace tick: the load wins and no advance occurs.
- Reset mid-pace or mid-load: reset wins; all state returns to reset values at that edge.
- From state 0 the sequence is 0x001, 0x003, 0x007, 0x00F, 0x01F, 0x03F, 0x07F, 0x0FE, …

Optional Feature:
- Macro: RAND_WRAP_FLAG_EN.
- Defined:
  - Adds output port wrapped (1 bit) and a WIDTH-bit register holding the start value.
  - The start value is set to 0 on reset and to the (lock-up-corrected) seed on seedLoad.
  - wrapped pulses for one cycle coincident with newValue when the advanced state equals the start value, i.e. every 1023 advances.
- Undefined: no wrapped port, no start register; all other behaviour is identical.

Decomposition:
- Package rand_pkg:
  - RAND_WIDTH = 10.
  - LOCKUP = 10'h3FF.
  - Tap index constants TAP_HI = 9 and TAP_LO = 6.
  - typedef rand_t = logic [RAND_WIDTH-1:0].
- Sub-module pace_counter (clk, Reset, enable, clear, tick): a parameterised modulo-PERIOD counter producing the advance strobe.
- The LFSR, seed handling and wrap detection stay in lfsr_rand_gen.

Test Plan:
- Reset held 4 cycles, then released with enable=0 → B=0x000 and newValue=0 throughout; B unchanged for 10 further cycles.
- PERIOD=4, enable held high from 0 → newValue pulses every 4th cycle, each pulse exactly 1 cycle; B steps 0x001, 0x003, 0x007, 0x00F.
- Enable dropped after 2 counted cycles for 5 cycles, then raised → the next advance occurs after exactly 2 more enabled cycles; B holds during the gap.
- seedLoad with seed=0x3FF → B=0x000 next cycle. seedLoad with seed=0x155 asserted on a pace-tick cycle → B=0x155, no advance, newValue=0; the next advance follows a full 4 enabled cycles.
- Reset asserted mid-count after B=0x007 → next cycle B=0x000, counter cleared, newValue=0.
- With RAND_WRAP_FLAG_EN, PERIOD=1, seed=0x2A5 → 1023 advances later B=0x2A5 and wrapped=1 for that single cycle; no 0x3FF is ever observed on B.
